// File: rtl/lebug_cfg_pkg.sv
// Shared config-bus types for the tracing instrumentation chain.
// Entry layout, reserved idle id and sequencer state encoding.
package lebug_cfg_pkg;

  localparam logic [7:0] NULL_CONFIG_ID = 8'hFF;

  typedef struct packed {
    logic [7:0] id;
    logic [7:0] data;
  } cfg_entry_t;

  typedef enum logic [1:0] {
    TRACE,
    DRAIN,
    WRITE,
    SETTLE
  } seq_state_t;

endpackage

// File: rtl/config_table.sv
// Register file of (configId, configData) entries for the sequencer.
// FIRMWARE_SEQ_READBACK_EN adds a registered readback port.
import lebug_cfg_pkg::*;

module config_table #(
  parameter int NUM_ENTRIES = 16
) (
  input  logic                           clk,
`ifdef FIRMWARE_SEQ_READBACK_EN
  input  logic                           reset,
  input  logic [$clog2(NUM_ENTRIES)-1:0] rd_addr,
  output cfg_entry_t                     rd_entry,
`endif
  input  logic                           we,
  input  logic [$clog2(NUM_ENTRIES)-1:0] waddr,
  input  cfg_entry_t                     wentry,
  input  logic [$clog2(NUM_ENTRIES)-1:0] raddr,
  output cfg_entry_t                     rentry
);

  cfg_entry_t mem [NUM_ENTRIES];

  // Host write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wentry;
  end

  assign rentry = mem[raddr];

`ifdef FIRMWARE_SEQ_READBACK_EN
  // Registered host readback, usable in any sequencer state.
  always_ff @(posedge clk) begin
    if (reset) rd_entry <= '0;
    else       rd_entry <= mem[rd_addr];
  end
`endif

endmodule

// File: rtl/firmware_sequencer.sv
// Drops tracing, drains, broadcasts the config table, restores tracing.
// FIRMWARE_SEQ_READBACK_EN adds rd_addr/rd_id/rd_data readback.
import lebug_cfg_pkg::*;

module firmware_sequencer #(
  parameter int         NUM_ENTRIES    = 16,
  parameter int         DRAIN_CYCLES   = 8,
  parameter logic [7:0] NULL_CONFIG_ID = lebug_cfg_pkg::NULL_CONFIG_ID
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start_reconfig,
  input  logic                             load_en,
  input  logic [$clog2(NUM_ENTRIES)-1:0]   load_addr,
  input  logic [7:0]                       load_id,
  input  logic [7:0]                       load_data,
  input  logic                             load_count_en,
  input  logic [$clog2(NUM_ENTRIES+1)-1:0] load_count,
`ifdef FIRMWARE_SEQ_READBACK_EN
  input  logic [$clog2(NUM_ENTRIES)-1:0]   rd_addr,
  output logic [7:0]                       rd_id,
  output logic [7:0]                       rd_data,
`endif
  output logic                             tracing,
  output logic [7:0]                       configId,
  output logic [7:0]                       configData,
  output logic                             busy,
  output logic                             done
);

  localparam int AW = $clog2(NUM_ENTRIES);
  localparam int CW = $clog2(NUM_ENTRIES + 1);
  localparam int DW = $clog2(DRAIN_CYCLES + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(NUM_ENTRIES);

  seq_state_t    state;
  logic [CW-1:0] count;
  logic [AW-1:0] idx;
  logic [DW-1:0] drain_cnt;

  logic          idle;
  logic          tbl_we;
  logic [CW-1:0] sat_count;
  logic [CW-1:0] eff_count;
  logic [AW-1:0] tbl_raddr;
  logic          last_entry;
  cfg_entry_t    tbl_wentry;
  cfg_entry_t    tbl_rentry;

  assign idle       = (state == TRACE);
  assign tbl_we     = load_en & idle;
  assign tbl_wentry = '{id: load_id, data: load_data};
  assign sat_count  = (load_count > MAX_CNT) ? MAX_CNT : load_count;
  assign eff_count  = (load_count_en && idle) ? sat_count : count;
  assign tbl_raddr  = (state == WRITE) ? idx + AW'(1) : '0;
  assign last_entry = (CW'(idx) + CW'(1)) == count;

`ifdef FIRMWARE_SEQ_READBACK_EN
  cfg_entry_t rd_entry;

  assign rd_id   = rd_entry.id;
  assign rd_data = rd_entry.data;
`endif

  config_table #(
    .NUM_ENTRIES (NUM_ENTRIES)
  ) u_table (
    .clk      (clk),
`ifdef FIRMWARE_SEQ_READBACK_EN
    .reset    (reset),
    .rd_addr  (rd_addr),
    .rd_entry (rd_entry),
`endif
    .we       (tbl_we),
    .waddr    (load_addr),
    .wentry   (tbl_wentry),
    .raddr    (tbl_raddr),
    .rentry   (tbl_rentry)
  );

  // Reconfiguration FSM; the next entry is registered straight onto the bus.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= TRACE;
      tracing    <= 1'b1;
      configId   <= NULL_CONFIG_ID;
      configData <= 8'h00;
      busy       <= 1'b0;
      done       <= 1'b0;
      count      <= '0;
      idx        <= '0;
      drain_cnt  <= '0;
    end else begin
      done <= 1'b0;
      if (idle && load_count_en) count <= sat_count;
      unique case (state)
        TRACE: begin
          if (start_reconfig && eff_count != '0) begin
            state     <= DRAIN;
            tracing   <= 1'b0;
            busy      <= 1'b1;
            drain_cnt <= DW'(DRAIN_CYCLES - 1);
          end
        end
        DRAIN: begin
          if (drain_cnt == '0) begin
            state      <= WRITE;
            idx        <= '0;
            configId   <= tbl_rentry.id;
            configData <= tbl_rentry.data;
          end else begin
            drain_cnt <= drain_cnt - DW'(1);
          end
        end
        WRITE: begin
          if (last_entry) begin
            state      <= SETTLE;
            configId   <= NULL_CONFIG_ID;
            configData <= 8'h00;
          end else begin
            idx        <= idx + AW'(1);
            configId   <= tbl_rentry.id;
            configData <= tbl_rentry.data;
          end
        end
        SETTLE: begin
          state   <= TRACE;
          tracing <= 1'b1;
          busy    <= 1'b0;
          done    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_firmware_sequencer.sv
// Self-checking bench for firmware_sequencer against a timeline model.
// Readback checks are built when FIRMWARE_SEQ_READBACK_EN is defined.
module tb_firmware_sequencer;

  localparam int N = 16;
  localparam int D = 8;
  localparam logic [7:0] NID = 8'hFF;
  localparam logic [18:0] IDLE = {1'b1, 1'b0, 1'b0, NID, 8'h00};

  logic       clk = 1'b0;
  logic       reset;
  logic       start_reconfig;
  logic       load_en;
  logic [3:0] load_addr;
  logic [7:0] load_id;
  logic [7:0] load_data;
  logic       load_count_en;
  logic [4:0] load_count;
  logic       tracing;
  logic [7:0] configId;
  logic [7:0] configData;
  logic       busy;
  logic       done;
`ifdef FIRMWARE_SEQ_READBACK_EN
  logic [3:0] rd_addr;
  logic [7:0] rd_id;
  logic [7:0] rd_data;
`endif

  logic [18:0] obs;
  assign obs = {tracing, busy, done, configId, configData};

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] m_id   [N];
  logic [7:0] m_data [N];
  int         m_count;

  firmware_sequencer #(
    .NUM_ENTRIES    (N),
    .DRAIN_CYCLES   (D),
    .NULL_CONFIG_ID (NID)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start_reconfig (start_reconfig),
    .load_en        (load_en),
    .load_addr      (load_addr),
    .load_id        (load_id),
    .load_data      (load_data),
    .load_count_en  (load_count_en),
    .load_count     (load_count),
`ifdef FIRMWARE_SEQ_READBACK_EN
    .rd_addr        (rd_addr),
    .rd_id          (rd_id),
    .rd_data        (rd_data),
`endif
    .tracing        (tracing),
    .configId       (configId),
    .configData     (configData),
    .busy           (busy),
    .done           (done)
  );

  always #5 clk = ~clk;

  // Expected {tracing,busy,done,id,data} t cycles after a start with cnt entries.
  function automatic logic [18:0] exp_out(int t, int cnt);
    if (t >= 1 && t <= D)
      return {1'b0, 1'b1, 1'b0, NID, 8'h00};
    if (t > D && t <= D + cnt)
      return {1'b0, 1'b1, 1'b0, m_id[t-D-1], m_data[t-D-1]};
    if (t == D + cnt + 1)
      return {1'b0, 1'b1, 1'b0, NID, 8'h00};
    if (t == D + cnt + 2)
      return {1'b1, 1'b0, 1'b1, NID, 8'h00};
    return IDLE;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(int a, logic [7:0] id, logic [7:0] d);
    load_en   = 1'b1;
    load_addr = 4'(a);
    load_id   = id;
    load_data = d;
    tick();
    load_en   = 1'b0;
    m_id[a]   = id;
    m_data[a] = d;
  endtask

  task automatic set_count(int c);
    load_count_en = 1'b1;
    load_count    = 5'(c);
    tick();
    load_count_en = 1'b0;
    m_count = (c > N) ? N : c;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    n_tests++;
    if (obs !== IDLE) begin
      n_fail++;
      $display("FAIL reset_state got %h want %h", obs, IDLE);
    end
`ifdef FIRMWARE_SEQ_READBACK_EN
    n_tests++;
    if ({rd_id, rd_data} !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_readback got %h want 0000", {rd_id, rd_data});
    end
`endif
    reset = 1'b0;
    m_count = 0;
  endtask

  task automatic test_empty_start();
    start_reconfig = 1'b1;
    for (int t = 1; t <= 20; t++) begin
      tick();
      start_reconfig = 1'b0;
      n_tests++;
      if (obs !== IDLE) begin
        n_fail++;
        $display("FAIL empty_start t=%0d got %h want %h", t, obs, IDLE);
      end
    end
  endtask

  task automatic test_basic();
    do_load(0, 8'd0, 8'd3);
    do_load(1, 8'd1, 8'd2);
    do_load(2, 8'd5, 8'd7);
    set_count(3);
    start_reconfig = 1'b1;
    for (int t = 1; t <= D + m_count + 3; t++) begin
      tick();
      start_reconfig = 1'b0;
      n_tests++;
      if (obs !== exp_out(t, m_count)) begin
        n_fail++;
        $display("FAIL basic t=%0d got %h want %h",
                 t, obs, exp_out(t, m_count));
      end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      for (int a = 0; a < N; a++)
        do_load(a, 8'($urandom_range(0, 254)), 8'($urandom));
      set_count($urandom_range(1, 31));
      start_reconfig = 1'b1;
      for (int t = 1; t <= D + m_count + 3; t++) begin
        tick();
        start_reconfig = 1'b0;
        n_tests++;
        if (obs !== exp_out(t, m_count)) begin
          n_fail++;
          $display("FAIL random it=%0d t=%0d got %h want %h",
                   it, t, obs, exp_out(t, m_count));
        end
      end
    end
  endtask

  task automatic test_saturation();
    set_count(N + 5);
    start_reconfig = 1'b1;
    for (int t = 1; t <= D + N + 3; t++) begin
      tick();
      start_reconfig = 1'b0;
      n_tests++;
      if (obs !== exp_out(t, N)) begin
        n_fail++;
        $display("FAIL saturation t=%0d got %h want %h",
                 t, obs, exp_out(t, N));
      end
    end
  endtask

  task automatic test_busy_start();
    do_load(0, 8'h11, 8'h22);
    set_count(2);
    start_reconfig = 1'b1;
    for (int t = 1; t <= D + 2 + 12; t++) begin
      tick();
      start_reconfig = 1'b0;
      load_en        = 1'b0;
      load_count_en  = 1'b0;
      if (t == 3) begin
        start_reconfig = 1'b1;
        load_en        = 1'b1;
        load_addr      = 4'd0;
        load_id        = 8'hAA;
        load_data      = 8'hBB;
        load_count_en  = 1'b1;
        load_count     = 5'd1;
      end
      n_tests++;
      if (obs !== exp_out(t, m_count)) begin
        n_fail++;
        $display("FAIL busy_start t=%0d got %h want %h",
                 t, obs, exp_out(t, m_count));
      end
    end
  endtask

  task automatic test_back_to_back();
    int l;
    int e;
    l = D + m_count + 2;
    start_reconfig = 1'b1;
    for (int t = 1; t <= 2 * l + 1; t++) begin
      tick();
      start_reconfig = (t == l);
      e = (t <= l) ? t : t - l;
      n_tests++;
      if (obs !== exp_out(e, m_count)) begin
        n_fail++;
        $display("FAIL back_to_back t=%0d got %h want %h",
                 t, obs, exp_out(e, m_count));
      end
    end
  endtask

  task automatic test_same_cycle();
    start_reconfig = 1'b1;
    load_en        = 1'b1;
    load_addr      = 4'd1;
    load_id        = 8'h3C;
    load_data      = 8'hC3;
    load_count_en  = 1'b1;
    load_count     = 5'd2;
    m_id[1]   = 8'h3C;
    m_data[1] = 8'hC3;
    m_count   = 2;
    for (int t = 1; t <= D + m_count + 3; t++) begin
      tick();
      start_reconfig = 1'b0;
      load_en        = 1'b0;
      load_count_en  = 1'b0;
      n_tests++;
      if (obs !== exp_out(t, m_count)) begin
        n_fail++;
        $display("FAIL same_cycle t=%0d got %h want %h",
                 t, obs, exp_out(t, m_count));
      end
    end
  endtask

`ifdef FIRMWARE_SEQ_READBACK_EN
  task automatic test_readback();
    int a;
    rd_addr = 4'd2;
    tick();
    n_tests++;
    if ({rd_id, rd_data} !== {m_id[2], m_data[2]}) begin
      n_fail++;
      $display("FAIL readback_idle got %h want %h",
               {rd_id, rd_data}, {m_id[2], m_data[2]});
    end
    start_reconfig = 1'b1;
    a = 2;
    for (int t = 1; t <= D + m_count + 3; t++) begin
      rd_addr = 4'(a);
      tick();
      start_reconfig = 1'b0;
      n_tests++;
      if ({rd_id, rd_data} !== {m_id[a], m_data[a]}) begin
        n_fail++;
        $display("FAIL readback_busy t=%0d got %h want %h",
                 t, {rd_id, rd_data}, {m_id[a], m_data[a]});
      end
      a = (a + 5) % N;
    end
  endtask
`endif

  task automatic test_reset_mid();
    do_load(0, 8'h01, 8'h10);
    do_load(1, 8'h02, 8'h20);
    do_load(2, 8'h03, 8'h30);
    set_count(3);
    start_reconfig = 1'b1;
    for (int t = 1; t <= D + 2; t++) begin
      tick();
      start_reconfig = 1'b0;
      n_tests++;
      if (obs !== exp_out(t, m_count)) begin
        n_fail++;
        $display("FAIL reset_mid_pre t=%0d got %h want %h",
                 t, obs, exp_out(t, m_count));
      end
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_count = 0;
    n_tests++;
    if (obs !== IDLE) begin
      n_fail++;
      $display("FAIL reset_mid got %h want %h", obs, IDLE);
    end
    start_reconfig = 1'b1;
    for (int t = 1; t <= 20; t++) begin
      tick();
      start_reconfig = 1'b0;
      n_tests++;
      if (obs !== IDLE) begin
        n_fail++;
        $display("FAIL reset_mid_start t=%0d got %h want %h",
                 t, obs, IDLE);
      end
    end
  endtask

  initial begin
    reset          = 1'b1;
    start_reconfig = 1'b0;
    load_en        = 1'b0;
    load_addr      = '0;
    load_id        = '0;
    load_data      = '0;
    load_count_en  = 1'b0;
    load_count     = '0;
`ifdef FIRMWARE_SEQ_READBACK_EN
    rd_addr        = '0;
`endif
    m_count        = 0;
    for (int a = 0; a < N; a++) begin
      m_id[a]   = 8'h00;
      m_data[a] = 8'h00;
    end
    tick();
    test_reset();
    test_empty_start();
    test_basic();
    test_random();
    test_saturation();
    test_busy_start();
    test_back_to_back();
    test_same_cycle();
`ifdef FIRMWARE_SEQ_READBACK_EN
    test_readback();
`endif
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
